// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared widths, requant saturation bounds and FSM state type
//               for the fully-connected neuron sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int c_DATA_W  = 8;
    localparam int c_ACC_W   = 32;
    localparam int c_ADDR_W  = 10;

    localparam int c_SAT_MAX = (1 << (c_DATA_W - 1)) - 1;
    localparam int c_SAT_MIN = -(1 << (c_DATA_W - 1));

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } fc_state_e;

endpackage
`default_nettype wire

// File: rtl/fc_requant.sv
`default_nettype none
// ============================================================================
// Module      : fc_requant
// Description : Combinational rounding right-shift, optional ReLU and
//               saturation of an accumulator down to the output width.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_requant
    import fc_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ACC_W  = c_ACC_W
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic        [4:0]        i_shift,
    input  logic                     i_relu_en,
    output logic signed [DATA_W-1:0] o_data
);

    localparam logic signed [ACC_W:0] c_HI = (ACC_W+1)'(c_SAT_MAX);
    localparam logic signed [ACC_W:0] c_LO = (ACC_W+1)'(c_SAT_MIN);

    // One guard bit keeps the rounding add from wrapping near full scale.
    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_half;
    logic signed [ACC_W:0] w_shifted;

    always_comb begin
        w_ext     = {i_acc[ACC_W-1], i_acc};
        w_half    = '0;
        if (i_shift != 5'd0) begin
            w_half = (ACC_W+1)'(1) << (i_shift - 5'd1);
        end
        w_shifted = (w_ext + w_half) >>> i_shift;

        if (i_relu_en && w_shifted[ACC_W]) begin
            o_data = '0;
        end else if (w_shifted > c_HI) begin
            o_data = DATA_W'(c_SAT_MAX);
        end else if (w_shifted < c_LO) begin
            o_data = DATA_W'(c_SAT_MIN);
        end else begin
            o_data = w_shifted[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_neuron_seq.sv
`default_nettype none
// ============================================================================
// Module      : fc_neuron_seq
// Description : Sequential fully-connected layer: per neuron reads bias,
//               MACs N activation/weight pairs, requantises and writes back.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_neuron_seq
    import fc_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ACC_W    = c_ACC_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int W_ADDR_W = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        in_len_i,
    input  logic [ADDR_W-1:0]        out_len_i,
    input  logic [4:0]               shift_i,
    input  logic                     relu_en_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     act_rd_en_o,
    output logic [ADDR_W-1:0]        act_rd_addr_o,
    input  logic signed [DATA_W-1:0] act_rd_data_i,
    output logic                     w_rd_en_o,
    output logic [W_ADDR_W-1:0]      w_rd_addr_o,
    input  logic signed [DATA_W-1:0] w_rd_data_i,
    output logic                     b_rd_en_o,
    output logic [ADDR_W-1:0]        b_rd_addr_o,
    input  logic signed [ACC_W-1:0]  b_rd_data_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic signed [DATA_W-1:0] wr_data_o
);

    fc_state_e                 r_state;
    logic [ADDR_W-1:0]         r_n;
    logic [ADDR_W-1:0]         r_m;
    logic [4:0]                r_shift;
    logic                      r_relu;
    logic [ADDR_W-1:0]         r_i;
    logic [ADDR_W-1:0]         r_j;
    logic [W_ADDR_W-1:0]       r_waddr;
    logic signed [ACC_W-1:0]   r_acc;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [DATA_W-1:0]   w_q;
    logic                       w_last_i;
    logic                       w_last_j;
    logic                       w_empty;

    assign w_prod     = act_rd_data_i * w_rd_data_i;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_last_i   = (r_i == r_n - ADDR_W'(1));
    assign w_last_j   = (r_j == r_m - ADDR_W'(1));
    assign w_empty    = (in_len_i == '0) || (out_len_i == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_m     <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_n     <= in_len_i;
                        r_m     <= out_len_i;
                        r_shift <= shift_i;
                        r_relu  <= relu_en_i;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_waddr <= '0;
                        r_state <= w_empty ? ST_DONE : ST_BIAS;
                    end
                end
                ST_BIAS: begin
                    r_i     <= '0;
                    r_state <= ST_MAC;
                end
                ST_MAC: begin
                    // Bias arrives on the first MAC cycle; products lag reads by one.
                    r_acc   <= (r_i == '0) ? b_rd_data_i : r_acc + w_prod_ext;
                    r_waddr <= r_waddr + W_ADDR_W'(1);
                    if (w_last_i) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_i <= r_i + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (w_last_j) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_j     <= r_j + ADDR_W'(1);
                        r_state <= ST_BIAS;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    fc_requant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_requant (
        .i_acc     (r_acc),
        .i_shift   (r_shift),
        .i_relu_en (r_relu),
        .o_data    (w_q)
    );

    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);
    assign act_rd_en_o   = (r_state == ST_MAC);
    assign w_rd_en_o     = (r_state == ST_MAC);
    assign act_rd_addr_o = (r_state == ST_MAC) ? r_i : '0;
    assign w_rd_addr_o   = (r_state == ST_MAC) ? r_waddr : '0;
    assign b_rd_en_o     = (r_state == ST_BIAS);
    assign b_rd_addr_o   = (r_state == ST_BIAS) ? r_j : '0;
    assign wr_en_o       = (r_state == ST_WRITE);
    assign wr_addr_o     = (r_state == ST_WRITE) ? r_j : '0;
    assign wr_data_o     = (r_state == ST_WRITE) ? w_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_fc_neuron_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_neuron_seq
// Description : Self-checking bench for fc_neuron_seq with memory models and
//               a behavioural reference of the neuron arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_neuron_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [9:0]        in_len = '0;
    logic [9:0]        out_len = '0;
    logic [4:0]        shift = '0;
    logic              relu = 1'b0;
    logic              busy, done;
    logic              act_en, w_en, b_en, wr_en;
    logic [9:0]        act_addr, b_addr, wr_addr;
    logic [19:0]       w_addr;
    logic signed [7:0] act_data = '0;
    logic signed [7:0] w_data = '0;
    logic signed [31:0] b_data = '0;
    logic signed [7:0] wr_data;

    fc_neuron_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .in_len_i      (in_len),
        .out_len_i     (out_len),
        .shift_i       (shift),
        .relu_en_i     (relu),
        .busy_o        (busy),
        .done_o        (done),
        .act_rd_en_o   (act_en),
        .act_rd_addr_o (act_addr),
        .act_rd_data_i (act_data),
        .w_rd_en_o     (w_en),
        .w_rd_addr_o   (w_addr),
        .w_rd_data_i   (w_data),
        .b_rd_en_o     (b_en),
        .b_rd_addr_o   (b_addr),
        .b_rd_data_i   (b_data),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data)
    );

    int checks = 0;
    int errors = 0;

    logic signed [7:0]  act_mem [0:1023];
    logic signed [7:0]  w_mem   [0:4095];
    logic signed [31:0] b_mem   [0:1023];

    // Synchronous 1-cycle-latency memories.
    always @(posedge clk) begin
        if (act_en) act_data <= act_mem[act_addr];
        if (w_en)   w_data   <= w_mem[w_addr[11:0]];
        if (b_en)   b_data   <= b_mem[b_addr];
    end

    int n_act, n_w, n_b, n_wr, n_bad, n_done;
    int wr_addr_q[$];
    int wr_data_q[$];

    always @(negedge clk) begin
        if (act_en) n_act++;
        if (w_en)   n_w++;
        if (b_en)   n_b++;
        if (done)   n_done++;
        if (wr_en) begin
            n_wr++;
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(int'(wr_data));
        end
        if (wr_en && (act_en || w_en || b_en)) n_bad++;
        if (act_en != w_en) n_bad++;
        if (!busy && (act_en || w_en || b_en || wr_en)) n_bad++;
    end

    task automatic clear_mon();
        n_act = 0; n_w = 0; n_b = 0; n_wr = 0; n_bad = 0; n_done = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Reference: exact sum with 32-bit wrap, then round/shift, ReLU, saturate.
    function automatic int exp_out(int j, int n, int sh, bit rl);
        int     acc;
        longint v;
        acc = b_mem[j];
        for (int i = 0; i < n; i++) acc += int'(act_mem[i]) * int'(w_mem[j*n + i]);
        v = longint'(acc);
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (rl && v < 0) v = 0;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    // Caller is at posedge+1. Config is scrambled after acceptance.
    task automatic run_job(input int n, input int m, input int sh, input bit rl,
                           output int lat, output bit ok, output bit bsy);
        clear_mon();
        in_len = 10'(n); out_len = 10'(m); shift = 5'(sh); relu = rl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bsy = busy;
        in_len = 10'($urandom()); out_len = 10'($urandom());
        shift = 5'($urandom()); relu = 1'($urandom());
        ok = 1'b0; lat = -1;
        for (int k = 0; k < 4000; k++) begin
            if (done) begin ok = 1'b1; lat = k; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if ({act_en, w_en, b_en, wr_en} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {act_en, w_en, b_en, wr_en});
        end
        checks++;
        if ({act_addr, w_addr, b_addr, wr_addr, wr_data} !== '0) begin
            errors++; $display("FAIL reset_addr_data: got %h expected 0", {act_addr, w_addr, b_addr, wr_addr, wr_data});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit ok, bsy;
        for (int i = 0; i < 4; i++) act_mem[i] = 8'(i + 1);
        for (int i = 0; i < 8; i++) w_mem[i] = 8'sd1;
        b_mem[0] = 0; b_mem[1] = 10;
        run_job(4, 2, 0, 1'b0, lat, ok, bsy);
        checks++;
        if (!ok || lat != 14) begin
            errors++; $display("FAIL basic_latency: got %0d (ok=%b) expected 14", lat, ok);
        end
        checks++;
        if (bsy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", bsy);
        end
        checks++;
        if (n_wr != 2 || n_act != 8 || n_b != 2 || n_bad != 0) begin
            errors++; $display("FAIL basic_counts: wr=%0d act=%0d b=%0d bad=%0d expected 2 8 2 0", n_wr, n_act, n_b, n_bad);
        end else begin
            checks++;
            if (wr_addr_q[0] != 0 || wr_data_q[0] != 10) begin
                errors++; $display("FAIL basic_w0: got addr %0d data %0d expected 0 10", wr_addr_q[0], wr_data_q[0]);
            end
            checks++;
            if (wr_addr_q[1] != 1 || wr_data_q[1] != 20) begin
                errors++; $display("FAIL basic_w1: got addr %0d data %0d expected 1 20", wr_addr_q[1], wr_data_q[1]);
            end
        end
    endtask

    task automatic test_saturate();
        int lat; bit ok, bsy;
        act_mem[0] = -8'sd128; w_mem[0] = -8'sd128; b_mem[0] = 0;
        run_job(1, 1, 7, 1'b0, lat, ok, bsy);
        checks++;
        if (!ok || lat != 4 || n_wr != 1) begin
            errors++; $display("FAIL sat_run: lat=%0d ok=%b wr=%0d expected 4 1 1", lat, ok, n_wr);
        end else begin
            checks++;
            if (wr_data_q[0] != 127) begin
                errors++; $display("FAIL sat_value: got %0d expected 127", wr_data_q[0]);
            end
        end
    endtask

    task automatic test_relu_round();
        int bias_t[6]  = '{-300, -300, 6, 5, -6, -7};
        int sh_t[6]    = '{0, 0, 2, 2, 2, 2};
        bit rl_t[6]    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int exp_t[6]   = '{0, -128, 2, 1, -1, -2};
        int lat; bit ok, bsy;
        act_mem[0] = 8'sd0; w_mem[0] = 8'sd0;
        for (int t = 0; t < 6; t++) begin
            b_mem[0] = bias_t[t];
            run_job(1, 1, sh_t[t], rl_t[t], lat, ok, bsy);
            checks++;
            if (!ok || n_wr != 1 || wr_data_q[0] != exp_t[t]) begin
                errors++;
                $display("FAIL requant_%0d: got %0d (wr=%0d ok=%b) expected %0d", t,
                         (n_wr > 0) ? wr_data_q[0] : 9999, n_wr, ok, exp_t[t]);
            end
        end
    endtask

    task automatic test_random();
        int lat; bit ok, bsy;
        for (int k = 0; k < 10; k++) begin
            int n, m, sh; bit rl;
            n = $urandom_range(1, 12); m = $urandom_range(1, 6);
            sh = $urandom_range(0, 12); rl = 1'($urandom());
            for (int i = 0; i < n; i++)     act_mem[i] = 8'($urandom());
            for (int i = 0; i < n * m; i++) w_mem[i]   = 8'($urandom());
            for (int j = 0; j < m; j++)
                b_mem[j] = ($urandom_range(0, 3) == 0) ? 32'($urandom())
                                                       : 32'(int'($urandom_range(0, 4000)) - 2000);
            run_job(n, m, sh, rl, lat, ok, bsy);
            checks++;
            if (!ok || lat != m * (n + 3)) begin
                errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, m * (n + 3));
            end
            checks++;
            if (n_wr != m || n_act != m * n || n_b != m || n_bad != 0) begin
                errors++;
                $display("FAIL rand%0d_counts: wr=%0d act=%0d b=%0d bad=%0d expected %0d %0d %0d 0",
                         k, n_wr, n_act, n_b, n_bad, m, m * n, m);
            end else begin
                for (int j = 0; j < m; j++) begin
                    checks++;
                    if (wr_addr_q[j] != j || wr_data_q[j] != exp_out(j, n, sh, rl)) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: got addr %0d data %0d expected %0d %0d",
                                 k, j, wr_addr_q[j], wr_data_q[j], j, exp_out(j, n, sh, rl));
                    end
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int lat; bit ok, bsy;
        run_job(0, 3, 0, 1'b0, lat, ok, bsy);
        checks++;
        if (!ok || lat != 0 || bsy !== 1'b1) begin
            errors++; $display("FAIL zero_n_timing: lat=%0d ok=%b busy=%b expected 0 1 1", lat, ok, bsy);
        end
        checks++;
        if (n_act + n_w + n_b + n_wr != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_n_strobes: strobes=%0d busy=%b expected 0 0", n_act + n_w + n_b + n_wr, busy);
        end
        run_job(3, 0, 0, 1'b0, lat, ok, bsy);
        checks++;
        if (!ok || lat != 0 || n_act + n_w + n_b + n_wr != 0) begin
            errors++; $display("FAIL zero_m: lat=%0d ok=%b strobes=%0d expected 0 1 0", lat, ok, n_act + n_w + n_b + n_wr);
        end
    endtask

    task automatic test_busy_start();
        bit ok;
        for (int i = 0; i < 5; i++)  act_mem[i] = 8'($urandom());
        for (int i = 0; i < 15; i++) w_mem[i]   = 8'($urandom());
        for (int j = 0; j < 3; j++)  b_mem[j]   = 32'(int'($urandom_range(0, 600)) - 300);
        clear_mon();
        in_len = 10'd5; out_len = 10'd3; shift = 5'd3; relu = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        in_len = 10'd2; out_len = 10'd1; shift = 5'd0; relu = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (!ok || n_wr != 3 || n_act != 15 || n_bad != 0) begin
            errors++; $display("FAIL busy_start_counts: ok=%b wr=%0d act=%0d bad=%0d expected 1 3 15 0", ok, n_wr, n_act, n_bad);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (wr_addr_q[j] != j || wr_data_q[j] != exp_out(j, 5, 3, 1'b0)) begin
                    errors++;
                    $display("FAIL busy_start_write%0d: got %0d %0d expected %0d %0d",
                             j, wr_addr_q[j], wr_data_q[j], j, exp_out(j, 5, 3, 1'b0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit; int lat; bit ok, bsy;
        for (int i = 0; i < 6; i++)  act_mem[i] = 8'($urandom());
        for (int i = 0; i < 18; i++) w_mem[i]   = 8'($urandom());
        for (int j = 0; j < 3; j++)  b_mem[j]   = 32'(int'($urandom_range(0, 200)) - 100);
        clear_mon();
        in_len = 10'd6; out_len = 10'd3; shift = 5'd2; relu = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (n_wr == 1 && act_en) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rstmid_reach: got no MAC on neuron 1 expected one");
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({act_en, w_en, b_en, wr_en, busy, done} !== 6'b0) begin
            errors++; $display("FAIL rstmid_outputs: got %b expected 000000", {act_en, w_en, b_en, wr_en, busy, done});
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_wr != 1 || n_done != 0) begin
            errors++; $display("FAIL rstmid_no_write: wr=%0d done=%0d expected 1 0", n_wr, n_done);
        end
        run_job(6, 3, 2, 1'b0, lat, ok, bsy);
        checks++;
        if (!ok || lat != 27 || n_wr != 3) begin
            errors++; $display("FAIL rstmid_restart: lat=%0d ok=%b wr=%0d expected 27 1 3", lat, ok, n_wr);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (wr_addr_q[j] != j || wr_data_q[j] != exp_out(j, 6, 2, 1'b0)) begin
                    errors++;
                    $display("FAIL rstmid_write%0d: got %0d %0d expected %0d %0d",
                             j, wr_addr_q[j], wr_data_q[j], j, exp_out(j, 6, 2, 1'b0));
                end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_saturate();
        test_relu_round();
        test_zero_len();
        test_random();
        test_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
